fetch_stage: RTL and testbench

Instruction-fetch stage for the 3-stage pipelined MIPS CPU. It owns the program counter, drives the instruction-memory address, and loads the IF/ID pipeline register consumed by the decode/execute stage. It also applies stall, branch redirect and flush requests from downstream, and keeps a fetched-instruction counter for bench visibility.

---
 rtl/fetch_stage.sv | 53 +++++
 tb/tb_fetch_stage.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, addresses instruction memory and loads
// the IF/ID register, applying reset > branch redirect > stall > advance.
module fetch_stage #(
    parameter int unsigned           PC_WIDTH  = 16,
    parameter int unsigned           IR_WIDTH  = 32,
    parameter logic [PC_WIDTH-1:0]   RESET_PC  = '0,
    parameter int unsigned           CNT_WIDTH = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 stall,
    input  logic                 branch_taken,
    input  logic [PC_WIDTH-1:0]  branch_target,
    input  logic [IR_WIDTH-1:0]  imem_data,
    output logic [PC_WIDTH-1:0]  imem_addr,
    output logic [PC_WIDTH-1:0]  PC,
    output logic [IR_WIDTH-1:0]  IFID_IR,
    output logic [PC_WIDTH-1:0]  IFID_PCplus4,
    output logic                 IFID_valid,
    output logic [CNT_WIDTH-1:0] fetch_count
);

    logic [PC_WIDTH-1:0] pc_plus4;
    logic [PC_WIDTH-1:0] target_aligned;

    // Wraps modulo 2^PC_WIDTH; the low two target bits are dropped on redirect.
    assign pc_plus4       = PC + PC_WIDTH'(4);
    assign target_aligned = {branch_target[PC_WIDTH-1:2], 2'b00};
    assign imem_addr      = PC;

    always_ff @(posedge clock) begin
        if (reset) begin
            PC           <= RESET_PC;
            IFID_IR      <= '0;
            IFID_PCplus4 <= '0;
            IFID_valid   <= 1'b0;
            fetch_count  <= '0;
        end else if (branch_taken) begin
            PC           <= target_aligned;
            IFID_IR      <= '0;
            IFID_PCplus4 <= '0;
            IFID_valid   <= 1'b0;
        end else if (!stall) begin
            PC           <= pc_plus4;
            IFID_IR      <= imem_data;
            IFID_PCplus4 <= pc_plus4;
            IFID_valid   <= 1'b1;
            if (fetch_count != '1)
                fetch_count <= fetch_count + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a reference model pushes expected IF state
// into a queue as each step is driven; entries are popped and checked after the edge.
module tb_fetch_stage;

    localparam int unsigned PW = 16;
    localparam int unsigned IW = 32;
    localparam int unsigned CW = 4;

    typedef struct {
        logic [PW-1:0] pc;
        logic [IW-1:0] ir;
        logic [PW-1:0] p4;
        logic          v;
        logic [CW-1:0] cnt;
    } exp_t;

    logic          clock = 1'b0;
    logic          reset, stall, branch_taken;
    logic [PW-1:0] branch_target;
    logic [IW-1:0] imem_data;
    logic [PW-1:0] imem_addr, PC, IFID_PCplus4;
    logic [IW-1:0] IFID_IR;
    logic          IFID_valid;
    logic [CW-1:0] fetch_count;

    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];
    exp_t m;

    always #5 clock = ~clock;

    fetch_stage #(
        .PC_WIDTH (PW),
        .IR_WIDTH (IW),
        .RESET_PC (16'h0000),
        .CNT_WIDTH(CW)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .imem_data    (imem_data),
        .imem_addr    (imem_addr),
        .PC           (PC),
        .IFID_IR      (IFID_IR),
        .IFID_PCplus4 (IFID_PCplus4),
        .IFID_valid   (IFID_valid),
        .fetch_count  (fetch_count)
    );

    function automatic logic [IW-1:0] mem_word(input logic [PW-1:0] a);
        case (a)
            16'h0000: return 32'h2009000f;
            16'h0004: return 32'h200a0007;
            16'h0008: return 32'h012a5824;
            default:  return {16'hC0DE, a};
        endcase
    endfunction

    always_comb imem_data = mem_word(imem_addr);

    task automatic chk(input string tag, input logic [IW-1:0] obs, input logic [IW-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic step(input logic rst, input logic stl, input logic br, input logic [PW-1:0] tgt);
        exp_t n, e;
        reset         = rst;
        stall         = stl;
        branch_taken  = br;
        branch_target = tgt;
        n = m;
        if (rst) begin
            n.pc = 16'h0000; n.ir = '0; n.p4 = '0; n.v = 1'b0; n.cnt = '0;
        end else if (br) begin
            n.pc = tgt & 16'hFFFC; n.ir = '0; n.p4 = '0; n.v = 1'b0;
        end else if (!stl) begin
            n.ir  = mem_word(m.pc);
            n.p4  = PW'(m.pc + 4);
            n.pc  = n.p4;
            n.v   = 1'b1;
            n.cnt = (m.cnt == {CW{1'b1}}) ? m.cnt : CW'(m.cnt + 1);
        end
        m = n;
        sb.push_back(n);
        @(posedge clock);
        #1;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard: observed=empty expected=entry");
        end else begin
            e = sb.pop_front();
            chk("PC",          IW'(PC),           IW'(e.pc));
            chk("imem_addr",   IW'(imem_addr),    IW'(e.pc));
            chk("IFID_IR",     IFID_IR,           e.ir);
            chk("IFID_PCplus4",IW'(IFID_PCplus4), IW'(e.p4));
            chk("IFID_valid",  IW'(IFID_valid),   IW'(e.v));
            chk("fetch_count", IW'(fetch_count),  IW'(e.cnt));
        end
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
        m = '{pc: '0, ir: '0, p4: '0, v: 1'b0, cnt: '0};
        @(negedge clock);

        // reset then free-run
        step(1, 0, 0, 16'h0000);
        step(0, 0, 0, 16'h0000);
        step(0, 0, 0, 16'h0000);
        // stall two cycles at PC=8, then release
        step(0, 1, 0, 16'h0000);
        step(0, 1, 0, 16'h0000);
        step(0, 0, 0, 16'h0000);
        // branch at PC=12 to 0x20, then load target
        step(0, 0, 1, 16'h0020);
        step(0, 0, 0, 16'h0000);
        // branch and stall together
        step(0, 1, 1, 16'h0004);
        step(0, 0, 0, 16'h0000);
        // wrap at top of address space
        step(0, 0, 1, 16'hFFFC);
        step(0, 0, 0, 16'h0000);
        step(0, 0, 0, 16'h0000);
        // unaligned target
        step(0, 0, 1, 16'h0013);
        step(0, 0, 0, 16'h0000);
        // drive the counter into saturation
        for (int i = 0; i < 14; i++) step(0, 0, 0, 16'h0000);
        step(0, 1, 0, 16'h0000);
        step(0, 0, 0, 16'h0000);
        // reset during a stall at PC=16
        step(0, 0, 1, 16'h0010);
        step(0, 1, 0, 16'h0000);
        step(1, 1, 0, 16'h0000);
        step(0, 0, 0, 16'h0000);
        step(0, 0, 0, 16'h0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
